program_loader: RTL



---
 rtl/cpu_pkg.sv | 33 +++
 rtl/program_loader.sv | 122 ++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared processor definitions: opcodes, instruction field layout and the
// program loader state encoding.
package cpu_pkg;

    typedef enum logic [3:0] {
        NOOP  = 4'd0,
        STORE = 4'd1,
        LOAD  = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        HALT  = 4'd5
    } opcode_e;

    // 16-bit instruction split into its four nibble fields, [15:12] first.
    typedef struct packed {
        logic [3:0] op;
        logic [3:0] f_a;
        logic [3:0] f_b;
        logic [3:0] f_c;
    } instr_t;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        HI,
        LO,
        WRITE,
        CSUM,
        DONE,
        ERR
    } loader_state_e;

endpackage

// File: rtl/program_loader.sv
// Loads a framed byte stream (count, big-endian words, XOR checksum) into
// instruction memory from address 0 and holds the controller in reset until it succeeds.
module program_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] I_addr,
    output logic [15:0]       I_data,
    output logic              I_wr,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // One extra bit so a full-memory count of 2**ADDR_W fits.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [8:0] MAX_N = 9'(1 << ADDR_W);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        acc_q, acc_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              accept;

    // All outputs decode registered state, so in_ready never depends on in_valid.
    assign in_ready  = state_q inside {COUNT, HI, LO, CSUM};
    assign busy      = state_q inside {COUNT, HI, LO, WRITE, CSUM};
    assign I_wr      = (state_q == WRITE);
    assign cpu_reset = (state_q != DONE);
    assign done      = (state_q == DONE);
    assign err       = (state_q == ERR);
    assign I_addr    = addr_q;
    assign I_data    = data_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path infers a latch.
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        hi_d    = hi_q;
        acc_d   = acc_q;
        rem_d   = rem_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = COUNT;
                    addr_d  = '0;
                    acc_d   = '0;
                end
            end
            COUNT: begin
                if (accept) begin
                    acc_d = acc_q ^ in_data;
                    rem_d = CNT_W'(in_data);
                    if ({1'b0, in_data} > MAX_N)
                        state_d = ERR;
                    else if (in_data == 8'h00)
                        state_d = CSUM;
                    else
                        state_d = HI;
                end
            end
            HI: begin
                if (accept) begin
                    hi_d    = in_data;
                    acc_d   = acc_q ^ in_data;
                    state_d = LO;
                end
            end
            LO: begin
                if (accept) begin
                    data_d  = {hi_q, in_data};
                    acc_d   = acc_q ^ in_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // Address wraps to 0 after a full-memory load; that value is never written.
                addr_d  = addr_q + ADDR_W'(1);
                rem_d   = rem_q - CNT_W'(1);
                state_d = (rem_q == CNT_W'(1)) ? CSUM : HI;
            end
            CSUM: begin
                if (accept)
                    state_d = (in_data == acc_q) ? DONE : ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; no memory array lives here, so every flop is reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            hi_q    <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            hi_q    <= hi_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
        end
    end

endmodule
